// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback queue entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;
  localparam int WB_DEPTH = 4;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_lookup.sv
// Youngest-match search of queued writebacks for one register read address.
// Latency: purely combinational.
// Backpressure: none; register 0 never hits.
module wb_bypass_lookup
  import cpu_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic [DEPTH-1:0]         vld_i,
  input  wb_entry_t                ent_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [REG_W-1:0]         look_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        fwd_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from the head (oldest) towards the tail so the last match is the youngest.
  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (vld_i[idx] && (ent_i[idx].rd == look_i) && (look_i != '0)) begin
        hit_o = 1'b1;
        fwd_o = ent_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// Writeback queue merging ALU and mul/div results into one regfile write port, with bypass.
// Latency: an accepted entry is written from the head the cycle after it is pushed at the earliest.
// Backpressure: ready derived from registered occupancy; en=0 freezes everything.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     alu_valid,
  input  logic [REG_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     md_valid,
  input  logic [REG_W-1:0]         md_rd,
  input  logic [DATA_W-1:0]        md_data,
  output logic                     alu_ready,
  output logic                     md_ready,
  output logic                     w_en,
  output logic [REG_W-1:0]         req_w,
  output logic [DATA_W-1:0]        data_w,
  input  logic [REG_W-1:0]         look_a,
  input  logic [REG_W-1:0]         look_b,
  output logic                     hit_a,
  output logic [DATA_W-1:0]        fwd_a,
  output logic                     hit_b,
  output logic [DATA_W-1:0]        fwd_b,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, wr_ptr;
  logic [CW-1:0]    count_q, count_d, free;
  logic             init_q;
  logic             act, pop, alu_push, md_push;
  logic             hit_a_raw, hit_b_raw;
  logic [DATA_W-1:0] fwd_a_raw, fwd_b_raw;

  // Handshake and head-of-queue outputs; init_q keeps ready low for the first cycle out of reset.
  always_comb begin
    act       = en & rst_n & init_q;
    free      = CW'(DEPTH) - count_q;
    alu_ready = act & (free >= CW'(1));
    md_ready  = act & ((free >= CW'(2)) | ((free >= CW'(1)) & ~alu_valid));
    alu_push  = alu_valid & alu_ready & (alu_rd != '0);
    md_push   = md_valid & md_ready & (md_rd != '0);
    pop       = act & (count_q != '0);
    w_en      = pop;
    req_w     = pop ? ent_q[head_q].rd : '0;
    data_w    = pop ? ent_q[head_q].data : '0;
    count     = rst_n ? count_q : '0;
    hit_a     = rst_n & hit_a_raw;
    fwd_a     = hit_a ? fwd_a_raw : '0;
    hit_b     = rst_n & hit_b_raw;
    fwd_b     = hit_b ? fwd_b_raw : '0;
  end

  // Next-state: pop the head, then append ALU (older) and MD (younger) at the tail.
  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    head_d  = head_q;
    wr_ptr  = tail_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (alu_push) begin
      ent_d[wr_ptr] = '{rd: alu_rd, data: alu_data};
      vld_d[wr_ptr] = 1'b1;
      wr_ptr        = wr_ptr + PW'(1);
    end
    if (md_push) begin
      ent_d[wr_ptr] = '{rd: md_rd, data: md_data};
      vld_d[wr_ptr] = 1'b1;
      wr_ptr        = wr_ptr + PW'(1);
    end
    tail_d  = wr_ptr;
    count_d = count_q + CW'(alu_push) + CW'(md_push) - CW'(pop);
  end

  // Control state: synchronous reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      init_q  <= 1'b0;
    end else if (en) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      init_q  <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity lives in vld_q.
  always_ff @(posedge clk) begin
    if (rst_n && en) ent_q <= ent_d;
  end

  wb_bypass_lookup #(.DEPTH(DEPTH)) u_look_a (
    .vld_i(vld_q), .ent_i(ent_q), .head_i(head_q), .look_i(look_a),
    .hit_o(hit_a_raw), .fwd_o(fwd_a_raw)
  );

  wb_bypass_lookup #(.DEPTH(DEPTH)) u_look_b (
    .vld_i(vld_q), .ent_i(ent_q), .head_i(head_q), .look_i(look_b),
    .hit_o(hit_b_raw), .fwd_o(fwd_b_raw)
  );
endmodule
